// File: rtl/cnn_weight_pkg.sv
// Shared constants and types for the CNN weight buffer.
//
// Holds the weight geometry (kernel edge, weights per RAM word, lane word
// width), the refill controller state encoding, and the helper that turns a
// half index into the first word address of that half. The values mirror the
// CNN parameter header used by the rest of the accelerator.
package cnn_weight_pkg;

    localparam int DATA_WIDTH              = 16;
    localparam int KERNEL_SIZE_MAX         = 3;
    localparam int PARA_KERNEL             = 4;
    localparam int WEIGHT_WRITE_ADDR_WIDTH = 8;
    localparam int WEIGHT_RAM_HALF         = 128;

    // Weights held by one RAM word, and the resulting lane word width.
    localparam int KS              = KERNEL_SIZE_MAX * KERNEL_SIZE_MAX;
    localparam int LANE_WORD_WIDTH = KS * DATA_WIDTH;

    // Refill controller states.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CHECK = 3'd1,
        S_REQ   = 3'd2,
        S_WAIT  = 3'd3,
        S_HOLD  = 3'd4
    } weight_fsm_e;

    // First word address of a half: half 0 starts at 0, half 1 at half_words.
    function automatic int unsigned half_base(input logic half, input int unsigned half_words);
        return half ? half_words : 32'd0;
    endfunction

endpackage

// File: rtl/weight_lane_ram.sv
// One kernel lane of the weight buffer.
//
// Single write port, single read port, read-first RAM. A read and a write to
// the same address on the same edge return the word that was stored before
// that edge. The output register is cleared by reset; the storage array is not.
//
// Ports:
//   clk, rst   : clock and synchronous active-high reset (output register only)
//   wr_en      : write strobe
//   wr_addr    : write word address
//   wr_data    : write word
//   rd_en      : read strobe; rd_data updates on the following edge
//   rd_addr    : read word address
//   rd_data    : registered read word
module weight_lane_ram #(
    parameter int WORD_WIDTH = 144,
    parameter int DEPTH      = 256,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [WORD_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [WORD_WIDTH-1:0] rd_data
);

    logic [WORD_WIDTH-1:0] mem [DEPTH];
    logic [WORD_WIDTH-1:0] rd_data_q;

    // Storage array, kept free of reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read register samples the array before this edge's write lands,
    // which gives the read-first behaviour.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q <= '0;
        end else if (rd_en) begin
            rd_data_q <= mem[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/weight_ram_bank.sv
// Ping-pong weight buffer between the weight-transmission stage and the PE array.
//
// Broadcast weight words are captured into PARA_KERNEL lane RAMs. The RAM is
// split into two halves: one is filled by upstream while the other is read by
// the PE array. A small controller tracks which halves hold valid weights and
// asks upstream for a refill whenever the other half is free.
//
// Ports:
//   clk, rst                : clock and synchronous active-high reset
//   weight_wr_en            : write strobe for the current broadcast word
//   weight_data             : one lane word per lane, lane 0 in the LSBs
//   write_weight_data_addr  : per-lane write word address
//   weight_data_done        : upstream done level; falls to acknowledge, rises when finished
//   update_weight_ram       : refill request, held until acknowledged
//   update_weight_ram_addr  : base of the half being requested, replicated per lane
//   init_weight_ram_ready   : sticky, set once the first half is full
//   rd_en, rd_half, rd_addr : read request (half select and offset within the half)
//   rd_data, rd_valid       : read word for all lanes, one cycle after the request
//   half_release            : consumer has finished with half release_half
//   release_half            : index of the half being released
//   half_full               : per-half full flags
//   addr_err                : sticky flag for an out-of-range lane write address
module weight_ram_bank #(
    parameter int DATA_WIDTH              = cnn_weight_pkg::DATA_WIDTH,
    parameter int KERNEL_SIZE_MAX         = cnn_weight_pkg::KERNEL_SIZE_MAX,
    parameter int PARA_KERNEL             = cnn_weight_pkg::PARA_KERNEL,
    parameter int WEIGHT_WRITE_ADDR_WIDTH = cnn_weight_pkg::WEIGHT_WRITE_ADDR_WIDTH,
    parameter int WEIGHT_RAM_HALF         = cnn_weight_pkg::WEIGHT_RAM_HALF
) (
    input  logic                                                        clk,
    input  logic                                                        rst,
    input  logic                                                        weight_wr_en,
    input  logic [KERNEL_SIZE_MAX*KERNEL_SIZE_MAX*PARA_KERNEL*DATA_WIDTH-1:0] weight_data,
    input  logic [WEIGHT_WRITE_ADDR_WIDTH*PARA_KERNEL-1:0]              write_weight_data_addr,
    input  logic                                                        weight_data_done,
    output logic                                                        update_weight_ram,
    output logic [WEIGHT_WRITE_ADDR_WIDTH*PARA_KERNEL-1:0]              update_weight_ram_addr,
    output logic                                                        init_weight_ram_ready,
    input  logic                                                        rd_en,
    input  logic                                                        rd_half,
    input  logic [WEIGHT_WRITE_ADDR_WIDTH-2:0]                          rd_addr,
    output logic [KERNEL_SIZE_MAX*KERNEL_SIZE_MAX*PARA_KERNEL*DATA_WIDTH-1:0] rd_data,
    output logic                                                        rd_valid,
    input  logic                                                        half_release,
    input  logic                                                        release_half,
    output logic [1:0]                                                  half_full,
    output logic                                                        addr_err
);

    import cnn_weight_pkg::*;

    localparam int WORD_BITS  = KERNEL_SIZE_MAX * KERNEL_SIZE_MAX * DATA_WIDTH;
    localparam int LANE_DEPTH = 2 * WEIGHT_RAM_HALF;
    localparam int RAM_AW     = $clog2(LANE_DEPTH);
    localparam int AW         = WEIGHT_WRITE_ADDR_WIDTH;

    weight_fsm_e       state_q, state_d;
    logic              fill_half_q, fill_half_d;
    logic [1:0]        half_full_q, half_full_d;
    logic              ready_q, ready_d;
    logic              update_q, update_d;
    logic              rd_valid_q, rd_valid_d;
    logic              addr_err_q, addr_err_d;
    logic              done_q, done_d;

    logic              done_rise;
    logic [PARA_KERNEL-1:0] lane_oob;
    logic [RAM_AW-1:0] rd_word_addr;
    logic [AW-1:0]     req_base;

    assign done_rise    = weight_data_done & ~done_q;
    assign rd_word_addr = RAM_AW'(half_base(rd_half, WEIGHT_RAM_HALF)) + RAM_AW'(rd_addr);
    assign req_base     = AW'(half_base(fill_half_q, WEIGHT_RAM_HALF));

    // Each lane writes its own slice at its own address; an address beyond the
    // lane depth drops only that lane's write and is reported through lane_oob.
    for (genvar k = 0; k < PARA_KERNEL; k++) begin : g_lane
        logic [AW-1:0] lane_waddr;
        logic          lane_in_range;

        assign lane_waddr    = write_weight_data_addr[k*AW +: AW];
        assign lane_in_range = (32'(lane_waddr) < 32'(LANE_DEPTH));
        assign lane_oob[k]   = ~lane_in_range;

        weight_lane_ram #(
            .WORD_WIDTH (WORD_BITS),
            .DEPTH      (LANE_DEPTH),
            .ADDR_WIDTH (RAM_AW)
        ) u_lane_ram (
            .clk     (clk),
            .rst     (rst),
            .wr_en   (weight_wr_en & lane_in_range),
            .wr_addr (lane_waddr[RAM_AW-1:0]),
            .wr_data (weight_data[k*WORD_BITS +: WORD_BITS]),
            .rd_en   (rd_en),
            .rd_addr (rd_word_addr),
            .rd_data (rd_data[k*WORD_BITS +: WORD_BITS])
        );
    end

    // Refill controller and flag next-state. The release clear is applied
    // before the state-specific set so that a set on the same half wins.
    always_comb begin
        state_d     = state_q;
        fill_half_d = fill_half_q;
        half_full_d = half_full_q;
        ready_d     = ready_q;

        if (half_release) begin
            half_full_d[release_half] = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                fill_half_d = 1'b0;
                if (done_rise) begin
                    half_full_d[0] = 1'b1;
                    ready_d        = 1'b1;
                    state_d        = S_CHECK;
                end
            end
            S_CHECK: begin
                // Only ask for a refill when the other half is free.
                if (!half_full_q[~fill_half_q]) begin
                    fill_half_d = ~fill_half_q;
                    state_d     = S_REQ;
                end else begin
                    state_d = S_HOLD;
                end
            end
            S_REQ: begin
                if (!weight_data_done) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (done_rise) begin
                    half_full_d[fill_half_q] = 1'b1;
                    state_d                  = S_CHECK;
                end
            end
            S_HOLD: begin
                if (half_release) begin
                    state_d = S_CHECK;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        update_d   = (state_d == S_REQ);
        rd_valid_d = rd_en & half_full_q[rd_half];
        addr_err_d = addr_err_q | (weight_wr_en & (|lane_oob));
        done_d     = weight_data_done;
    end

    // All control state and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            fill_half_q <= 1'b0;
            half_full_q <= 2'b00;
            ready_q     <= 1'b0;
            update_q    <= 1'b0;
            rd_valid_q  <= 1'b0;
            addr_err_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            fill_half_q <= fill_half_d;
            half_full_q <= half_full_d;
            ready_q     <= ready_d;
            update_q    <= update_d;
            rd_valid_q  <= rd_valid_d;
            addr_err_q  <= addr_err_d;
            done_q      <= done_d;
        end
    end

    assign update_weight_ram      = update_q;
    assign update_weight_ram_addr = update_q ? {PARA_KERNEL{req_base}} : '0;
    assign init_weight_ram_ready  = ready_q;
    assign rd_valid               = rd_valid_q;
    assign half_full              = half_full_q;
    assign addr_err               = addr_err_q;

endmodule
